// File: rtl/output_port_scheduler_if.sv
// output_port_scheduler_if
//  Bundles the flit-level signals between one output port scheduler, the four
//  input interfaces that can target it, and its downstream link.
//
//  Signals:
//   req       input k holds a flit for this port (one bit per input)
//   vc        VC bit of each input's flit
//   in_data   flit of input k in bits [DATA_WIDTH*k +: DATA_WIDTH]
//   clr       one-cycle pulse telling input k its flit was accepted
//   so        send-out valid towards the downstream link
//   ro        downstream ready for the VC currently being drained
//   out_data  flit presented to the downstream link
//
//  Modports:
//   master    the surrounding router/link side (drives requests and ready)
//   slave     the scheduler itself
interface output_port_scheduler_if #(
   parameter int DATA_WIDTH = 64,
   parameter int NUM_REQ    = 4
);

   logic [NUM_REQ-1:0]            req;
   logic [NUM_REQ-1:0]            vc;
   logic [NUM_REQ*DATA_WIDTH-1:0] in_data;
   logic [NUM_REQ-1:0]            clr;
   logic                          so;
   logic                          ro;
   logic [DATA_WIDTH-1:0]         out_data;

   modport master (
      output req, vc, in_data, ro,
      input  clr, so, out_data
   );

   modport slave (
      input  req, vc, in_data, ro,
      output clr, so, out_data
   );

endinterface

// File: rtl/output_port_scheduler.sv
// output_port_scheduler
//  Per-output-port controller of the 5-port mesh router. Round-robin arbitrates
//  among the four inputs that target this port and keeps a two-slot output
//  buffer, one slot per virtual channel. Each cycle the slot of VC[polarity] is
//  filled from the winning input (which gets a clear pulse back) while the slot
//  of VC[~polarity] is offered to the downstream link.
//
//  Ports:
//   clk       rising-edge clock
//   reset     synchronous, active-low reset
//   polarity  router-wide polarity, toggles every cycle (input only)
//   bus       flit request/accept and downstream handshake (slave modport)
//   full_o    full_o[v]: slot of VC v is occupied (status)
//   grant_o   {valid, index} of this cycle's grant (status)
module output_port_scheduler #(
   parameter int DATA_WIDTH = 64,
   parameter int NUM_REQ    = 4
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        polarity,
   output_port_scheduler_if.slave      bus,
   output logic [1:0]                  full_o,
   output logic [2:0]                  grant_o
);

   logic [1:0]            full;
   logic [DATA_WIDTH-1:0] slot [2];
   logic [1:0]            rr_ptr;
   logic [NUM_REQ-1:0]    clr_q;
   logic [NUM_REQ-1:0]    elig;
   logic                  grant_valid;
   logic [1:0]            winner;

   // An input may compete only when its flit belongs to the VC being filled
   // this cycle and that VC's slot is free. Holding reset low suppresses all
   // grants so the status output reads zero while the block is in reset.
   always_comb begin
      elig = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         elig[k] = reset & bus.req[k] & (bus.vc[k] == polarity) & ~full[polarity];
      end
   end

   // Round-robin scan starting at rr_ptr. The 2-bit index wraps naturally,
   // so rr_ptr + i walks rr_ptr, rr_ptr+1, ... modulo 4.
   always_comb begin
      grant_valid = 1'b0;
      winner      = 2'd0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!grant_valid && elig[rr_ptr + 2'(i)]) begin
            grant_valid = 1'b1;
            winner      = rr_ptr + 2'(i);
         end
      end
   end

   // Fill and drain always touch opposite slots within a cycle, so both can
   // update in the same edge without conflict. The pointer moves past the
   // winner only when something was granted; one pointer serves both VCs.
   always_ff @(posedge clk) begin
      if (!reset) begin
         full    <= 2'b00;
         slot[0] <= '0;
         slot[1] <= '0;
         rr_ptr  <= 2'd0;
         clr_q   <= '0;
      end else begin
         clr_q <= '0;
         if (grant_valid) begin
            slot[polarity] <= bus.in_data[winner*DATA_WIDTH +: DATA_WIDTH];
            full[polarity] <= 1'b1;
            rr_ptr         <= winner + 2'd1;
            clr_q          <= NUM_REQ'(1) << winner;
         end
         if (full[~polarity] && bus.ro) begin
            full[~polarity] <= 1'b0;
         end
      end
   end

   // Downstream valid and data come straight from registered state selected by
   // polarity; ro never feeds back combinationally into so.
   assign bus.clr      = clr_q;
   assign bus.so       = full[~polarity];
   assign bus.out_data = slot[~polarity];
   assign full_o       = full;
   assign grant_o      = {grant_valid, winner};

endmodule

// File: tb/tb_output_port_scheduler.sv
// tb_output_port_scheduler
//  Directed bench for output_port_scheduler. Inputs are driven on the falling
//  edge; outputs are compared two time units later, well away from the rising
//  edge. Registered outputs (clr, full) therefore show the result of the
//  previous step, while grant/so/data reflect the inputs of the current step.
module tb_output_port_scheduler;

   localparam logic [63:0] D0 = 64'h0123_4567_89AB_CDE0;
   localparam logic [63:0] D1 = 64'hFEDC_BA98_7654_3211;
   localparam logic [63:0] D2 = 64'h0000_0000_0000_00A5;
   localparam logic [63:0] D3 = 64'h3C3C_5A5A_C3C3_A5A3;

   logic       clk;
   logic       reset;
   logic       polarity;
   logic [1:0] full_o;
   logic [2:0] grant_o;

   int checkCount;
   int errorCount;

   output_port_scheduler_if #(.DATA_WIDTH(64), .NUM_REQ(4)) bus ();

   output_port_scheduler #(.DATA_WIDTH(64), .NUM_REQ(4)) dut (
      .clk      (clk),
      .reset    (reset),
      .polarity (polarity),
      .bus      (bus),
      .full_o   (full_o),
      .grant_o  (grant_o)
   );

   // Free-running clock, 10 time units per cycle.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Safety net so the run always ends even if the stimulus stalls.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog expired before the end of stimulus");
      $fatal(1, "[TB] watchdog");
   end

   // Drive one cycle's worth of inputs on the falling edge, then settle.
   task automatic applyStimulus(input logic rst, input logic pol, input logic [3:0] req,
                                input logic [3:0] vc, input logic ro);
      @(negedge clk);
      reset    = rst;
      polarity = pol;
      bus.req  = req;
      bus.vc   = vc;
      bus.ro   = ro;
      #2;
   endtask

   // Compare every observable output against the hand-computed expectation.
   task automatic checkOutput(input string tag, input logic [2:0] expGrant, input logic [3:0] expClr,
                              input logic expSo, input logic [1:0] expFull, input logic [63:0] expData);
      checkCount++;
      assert (grant_o === expGrant) else begin
         errorCount++;
         $error("[TB] FAIL %s grant got %b expected %b", tag, grant_o, expGrant);
      end
      checkCount++;
      assert (bus.clr === expClr) else begin
         errorCount++;
         $error("[TB] FAIL %s clr got %b expected %b", tag, bus.clr, expClr);
      end
      checkCount++;
      assert (bus.so === expSo) else begin
         errorCount++;
         $error("[TB] FAIL %s so got %b expected %b", tag, bus.so, expSo);
      end
      checkCount++;
      assert (full_o === expFull) else begin
         errorCount++;
         $error("[TB] FAIL %s full got %b expected %b", tag, full_o, expFull);
      end
      checkCount++;
      assert (bus.out_data === expData) else begin
         errorCount++;
         $error("[TB] FAIL %s data got %h expected %h", tag, bus.out_data, expData);
      end
   endtask

   // Linear directed sequence: each step drives inputs and checks outputs.
   initial begin
      checkCount  = 0;
      errorCount  = 0;
      reset       = 1'b0;
      polarity    = 1'b0;
      bus.req     = 4'b0000;
      bus.vc      = 4'b0000;
      bus.ro      = 1'b0;
      bus.in_data = {D3, D2, D1, D0};

      // Reset held low for two edges.
      applyStimulus(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0);
      applyStimulus(1'b0, 1'b0, 4'b0100, 4'b0000, 1'b0);
      checkOutput("reset",     3'b000, 4'b0000, 1'b0, 2'b00, 64'h0);

      // Single request from input 2 on VC0, then drain it.
      applyStimulus(1'b1, 1'b0, 4'b0100, 4'b0000, 1'b0);
      checkOutput("t1_grant",  3'b110, 4'b0000, 1'b0, 2'b00, 64'h0);
      applyStimulus(1'b1, 1'b1, 4'b0000, 4'b0000, 1'b0);
      checkOutput("t1_clr",    3'b000, 4'b0100, 1'b1, 2'b01, D2);
      applyStimulus(1'b1, 1'b0, 4'b0000, 4'b0000, 1'b1);
      checkOutput("t1_other",  3'b000, 4'b0000, 1'b0, 2'b01, 64'h0);
      applyStimulus(1'b1, 1'b1, 4'b0000, 4'b0000, 1'b1);
      checkOutput("t1_drain",  3'b000, 4'b0000, 1'b1, 2'b01, D2);

      // All four requesting every cycle with matching VC, link always ready.
      applyStimulus(1'b1, 1'b0, 4'b1111, 4'b0000, 1'b1);
      checkOutput("t2_c0",     3'b111, 4'b0000, 1'b0, 2'b00, 64'h0);
      applyStimulus(1'b1, 1'b1, 4'b1111, 4'b1111, 1'b1);
      checkOutput("t2_c1",     3'b100, 4'b1000, 1'b1, 2'b01, D3);
      applyStimulus(1'b1, 1'b0, 4'b1111, 4'b0000, 1'b1);
      checkOutput("t2_c2",     3'b101, 4'b0001, 1'b1, 2'b10, D0);
      applyStimulus(1'b1, 1'b1, 4'b1111, 4'b1111, 1'b1);
      checkOutput("t2_c3",     3'b110, 4'b0010, 1'b1, 2'b01, D1);
      applyStimulus(1'b1, 1'b0, 4'b1111, 4'b0000, 1'b1);
      checkOutput("t2_c4",     3'b111, 4'b0100, 1'b1, 2'b10, D2);
      applyStimulus(1'b1, 1'b1, 4'b0000, 4'b0000, 1'b1);
      checkOutput("t2_c5",     3'b000, 4'b1000, 1'b1, 2'b01, D3);

      // Backpressure: fill both slots with the link stalled, then release.
      applyStimulus(1'b1, 1'b0, 4'b1111, 4'b0000, 1'b0);
      checkOutput("t3_fill0",  3'b100, 4'b0000, 1'b0, 2'b00, D2);
      applyStimulus(1'b1, 1'b1, 4'b1111, 4'b1111, 1'b0);
      checkOutput("t3_fill1",  3'b101, 4'b0001, 1'b1, 2'b01, D0);
      applyStimulus(1'b1, 1'b0, 4'b1111, 4'b0000, 1'b0);
      checkOutput("t3_block0", 3'b000, 4'b0010, 1'b1, 2'b11, D1);
      applyStimulus(1'b1, 1'b1, 4'b1111, 4'b1111, 1'b0);
      checkOutput("t3_block1", 3'b000, 4'b0000, 1'b1, 2'b11, D0);
      applyStimulus(1'b1, 1'b0, 4'b1111, 4'b0000, 1'b1);
      checkOutput("t3_drain1", 3'b000, 4'b0000, 1'b1, 2'b11, D1);
      applyStimulus(1'b1, 1'b1, 4'b1111, 4'b1111, 1'b1);
      checkOutput("t3_resume", 3'b110, 4'b0000, 1'b1, 2'b01, D0);
      applyStimulus(1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0);
      checkOutput("t3_after",  3'b000, 4'b0100, 1'b1, 2'b10, D2);

      // Fill VC0 from input 3 while VC1 drains on the same edge.
      applyStimulus(1'b1, 1'b0, 4'b1000, 4'b0000, 1'b1);
      checkOutput("t5_both",   3'b111, 4'b0000, 1'b1, 2'b10, D2);
      applyStimulus(1'b1, 1'b1, 4'b0000, 4'b0000, 1'b1);
      checkOutput("t5_result", 3'b000, 4'b1000, 1'b1, 2'b01, D3);

      // VC filter: input 0 carries VC0, so no grant while polarity is 1.
      applyStimulus(1'b1, 1'b1, 4'b0001, 4'b0000, 1'b0);
      checkOutput("t4_nogrant", 3'b000, 4'b0000, 1'b0, 2'b00, D3);
      applyStimulus(1'b1, 1'b0, 4'b0001, 4'b0000, 1'b0);
      checkOutput("t4_grant",  3'b100, 4'b0000, 1'b0, 2'b00, D2);
      applyStimulus(1'b1, 1'b1, 4'b0100, 4'b0100, 1'b0);
      checkOutput("t4_clr",    3'b110, 4'b0001, 1'b1, 2'b01, D0);

      // Reset with both slots full and a clear pulse outstanding.
      applyStimulus(1'b0, 1'b0, 4'b1111, 4'b0000, 1'b0);
      checkOutput("t6_inrst",  3'b000, 4'b0100, 1'b1, 2'b11, D2);
      applyStimulus(1'b1, 1'b1, 4'b1111, 4'b1111, 1'b0);
      checkOutput("t6_release", 3'b100, 4'b0000, 1'b0, 2'b00, 64'h0);
      applyStimulus(1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0);
      checkOutput("t6_first",  3'b000, 4'b0001, 1'b1, 2'b10, D0);

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
